midi_tx: RTL and testbench

MIDI_TX -- requirements
Module: midi_tx

---
 rtl/midi_tx_pkg.sv | 24 ++
 rtl/sync_fifo.sv | 68 ++++++
 rtl/midi_tx.sv | 152 +++++++++++++++
 tb/tb_midi_tx.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/midi_tx_pkg.sv
// Shared cartridge package: MIDI transmitter state encoding, default baud
// divider and register-address constants used by the register decode.
package midi_tx_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } midi_state_e;

    // 1 MHz system clock / 32 = 31250 baud
    localparam int MIDI_CLK_DIV = 32;

    localparam logic [7:0] REG_MIDI_DATA   = 8'h40;
    localparam logic [7:0] REG_MIDI_STATUS = 8'h41;
    localparam logic [7:0] REG_MIDI_CTRL   = 8'h42;

    // Baud counter width; a divider of 1 still needs a 1-bit counter
    function automatic int baud_width(input int div);
        return (div > 1) ? $clog2(div) : 1;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with occupancy count; writes while full are ignored,
// reads while empty are ignored. Read data is the current head (no bypass).
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   wr_en_i,
    input  logic [WIDTH-1:0]       wr_data_i,
    input  logic                   rd_en_i,
    output logic [WIDTH-1:0]       rd_data_o,
    output logic                   full_o,
    output logic                   empty_o,
    output logic [$clog2(DEPTH):0] level_o
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_L = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             wr_ok, rd_ok;

    assign full_o    = (count_q == DEPTH_L);
    assign empty_o   = (count_q == '0);
    assign level_o   = count_q;
    assign rd_data_o = mem_q[rd_ptr_q];

    // Full/empty are judged on the pre-edge occupancy, so a write while
    // full is dropped even if a pop happens in the same cycle.
    assign wr_ok = wr_en_i && !full_o;
    assign rd_ok = rd_en_i && !empty_o;

    // Pointer and occupancy next-state; pointers wrap on their natural width
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (wr_ok) wr_ptr_d = wr_ptr_q + 1'b1;
        if (rd_ok) rd_ptr_d = rd_ptr_q + 1'b1;
        case ({wr_ok, rd_ok})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Pointer and occupancy registers
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array, written at the tail
    always_ff @(posedge clk_i) begin
        if (wr_ok) mem_q[wr_ptr_q] <= wr_data_i;
    end

endmodule

// File: rtl/midi_tx.sv
// MIDI 8N1 serial transmitter: byte FIFO feeding a START/DATA/STOP
// serializer with a registered txd output and a sticky overflow flag.
module midi_tx
    import midi_tx_pkg::*;
#(
    parameter int CLK_DIV    = MIDI_CLK_DIV,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        wr_en,
    input  logic [7:0]                  wr_data,
    input  logic                        clr_ovf,
    output logic                        txd,
    output logic                        full,
    output logic                        empty,
    output logic                        busy,
    output logic                        overflow,
    output logic [$clog2(FIFO_DEPTH):0] level
);
    localparam int            BW       = baud_width(CLK_DIV);
    localparam logic [BW-1:0] BAUD_MAX = BW'(CLK_DIV - 1);

    midi_state_e   state_q, state_d;
    logic [BW-1:0] baud_q, baud_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    sh_q, sh_d;
    logic          txd_q, txd_d;
    logic          ovf_q, ovf_d;
    logic          pop;
    logic          baud_wrap;
    logic [7:0]    fifo_data;

    sync_fifo #(
        .WIDTH(8),
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk_i    (clock),
        .rst_i    (reset),
        .wr_en_i  (wr_en),
        .wr_data_i(wr_data),
        .rd_en_i  (pop),
        .rd_data_o(fifo_data),
        .full_o   (full),
        .empty_o  (empty),
        .level_o  (level)
    );

    assign baud_wrap = (baud_q == BAUD_MAX);
    assign txd       = txd_q;
    assign busy      = (state_q != ST_IDLE);
    assign overflow  = ovf_q;

    // Serializer next-state, next txd level, FIFO pop and overflow flag
    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        sh_d    = sh_q;
        txd_d   = txd_q;
        pop     = 1'b0;

        // set wins over clear when a write is dropped in the same cycle
        ovf_d = ovf_q;
        if (clr_ovf)       ovf_d = 1'b0;
        if (wr_en && full) ovf_d = 1'b1;

        case (state_q)
            ST_IDLE: begin
                txd_d = 1'b1;
                if (!empty) begin
                    pop     = 1'b1;
                    sh_d    = fifo_data;
                    state_d = ST_START;
                    txd_d   = 1'b0;
                    baud_d  = '0;
                    bit_d   = '0;
                end
            end
            ST_START: begin
                if (baud_wrap) begin
                    state_d = ST_DATA;
                    baud_d  = '0;
                    bit_d   = '0;
                    txd_d   = sh_q[0];
                    sh_d    = {1'b0, sh_q[7:1]};
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            ST_DATA: begin
                if (baud_wrap) begin
                    baud_d = '0;
                    if (bit_q == 3'd7) begin
                        state_d = ST_STOP;
                        bit_d   = '0;
                        txd_d   = 1'b1;
                    end else begin
                        bit_d = bit_q + 3'd1;
                        txd_d = sh_q[0];
                        sh_d  = {1'b0, sh_q[7:1]};
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            ST_STOP: begin
                if (baud_wrap) begin
                    baud_d = '0;
                    bit_d  = '0;
                    if (!empty) begin
                        pop     = 1'b1;
                        sh_d    = fifo_data;
                        state_d = ST_START;
                        txd_d   = 1'b0;
                    end else begin
                        state_d = ST_IDLE;
                        txd_d   = 1'b1;
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                txd_d   = 1'b1;
                baud_d  = '0;
                bit_d   = '0;
            end
        endcase
    end

    // Serializer state, counters, shift register, txd and overflow registers
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            sh_q    <= '0;
            txd_q   <= 1'b1;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            sh_q    <= sh_d;
            txd_q   <= txd_d;
            ovf_q   <= ovf_d;
        end
    end

endmodule

// File: tb/tb_midi_tx.sv
// Bench for midi_tx: two instances (CLK_DIV=32 and CLK_DIV=3) share one
// stimulus stream; each is compared every cycle against a frame-position model.
module tb_midi_tx;

    localparam int DEPTH = 4;
    localparam int DIV_A = 32;
    localparam int DIV_B = 3;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       wr_en = 1'b0;
    logic [7:0] wr_data = '0;
    logic       clr_ovf = 1'b0;

    logic       txd_a, full_a, empty_a, busy_a, ovf_a;
    logic [2:0] level_a;
    logic       txd_b, full_b, empty_b, busy_b, ovf_b;
    logic [2:0] level_b;

    int vectors = 0;
    int miscompares = 0;

    midi_tx #(.CLK_DIV(DIV_A), .FIFO_DEPTH(DEPTH)) u_dut (
        .clock(clock), .reset(reset), .wr_en(wr_en), .wr_data(wr_data),
        .clr_ovf(clr_ovf), .txd(txd_a), .full(full_a), .empty(empty_a),
        .busy(busy_a), .overflow(ovf_a), .level(level_a)
    );

    midi_tx #(.CLK_DIV(DIV_B), .FIFO_DEPTH(DEPTH)) u_dut3 (
        .clock(clock), .reset(reset), .wr_en(wr_en), .wr_data(wr_data),
        .clr_ovf(clr_ovf), .txd(txd_b), .full(full_b), .empty(empty_b),
        .busy(busy_b), .overflow(ovf_b), .level(level_b)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model: a byte queue plus "position within current frame"
    logic [7:0] mq    [2][8];
    int         mcnt  [2];
    int         mpos  [2];
    bit         mact  [2];
    bit         movf  [2];
    logic [7:0] mbyte [2];

    task automatic model_reset(input int k);
        mcnt[k] = 0; mpos[k] = 0; mact[k] = 1'b0; movf[k] = 1'b0; mbyte[k] = '0;
    endtask

    task automatic model_step(input int k, input int d);
        int  pre;
        bit  start;
        pre   = mcnt[k];
        start = 1'b0;
        if (clr_ovf) movf[k] = 1'b0;
        if (wr_en && pre == DEPTH) movf[k] = 1'b1;
        if (mact[k]) begin
            mpos[k]++;
            if (mpos[k] == 10 * d) begin
                if (pre > 0) start = 1'b1;
                else mact[k] = 1'b0;
            end
        end else if (pre > 0) begin
            start = 1'b1;
        end
        if (start) begin
            mbyte[k] = mq[k][0];
            for (int unsigned i = 0; i < 7; i++) mq[k][i] = mq[k][i+1];
            mcnt[k]--;
            mact[k] = 1'b1;
            mpos[k] = 0;
        end
        if (wr_en && pre < DEPTH) begin
            mq[k][mcnt[k]] = wr_data;
            mcnt[k]++;
        end
    endtask

    function automatic logic exp_txd(input int k, input int d);
        int b;
        if (!mact[k]) return 1'b1;
        b = mpos[k] / d;
        if (b == 0) return 1'b0;
        if (b <= 8) return mbyte[k][b-1];
        return 1'b1;
    endfunction

    function automatic int exp_baud(input int k, input int d);
        return mact[k] ? (mpos[k] % d) : 0;
    endfunction

    // Model advances on the same edges as the DUTs
    always @(posedge clock or posedge reset) begin
        if (reset) begin
            model_reset(0);
            model_reset(1);
        end else begin
            model_step(0, DIV_A);
            model_step(1, DIV_B);
        end
    end

    // Compare every output of both instances on the falling edge
    always @(negedge clock) begin
        check("txd32",   32'(txd_a),   32'(exp_txd(0, DIV_A)));
        check("busy32",  32'(busy_a),  32'(mact[0]));
        check("level32", 32'(level_a), mcnt[0]);
        check("full32",  32'(full_a),  32'(mcnt[0] == DEPTH));
        check("empty32", 32'(empty_a), 32'(mcnt[0] == 0));
        check("ovf32",   32'(ovf_a),   32'(movf[0]));
        check("baud32",  32'(u_dut.baud_q), exp_baud(0, DIV_A));
        check("txd3",    32'(txd_b),   32'(exp_txd(1, DIV_B)));
        check("busy3",   32'(busy_b),  32'(mact[1]));
        check("level3",  32'(level_b), mcnt[1]);
        check("full3",   32'(full_b),  32'(mcnt[1] == DEPTH));
        check("empty3",  32'(empty_b), 32'(mcnt[1] == 0));
        check("ovf3",    32'(ovf_b),   32'(movf[1]));
        check("baud3",   32'(u_dut3.baud_q), exp_baud(1, DIV_B));
    end

    task automatic cyc(input logic w, input logic [7:0] d, input logic c);
        wr_en = w; wr_data = d; clr_ovf = c;
        @(negedge clock);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 8'h00, 1'b0);
    endtask

    logic [7:0] seq3 [3];
    logic [7:0] seq6 [6];

    initial begin
        seq3[0] = 8'h90; seq3[1] = 8'h3C; seq3[2] = 8'h7F;
        seq6[0] = 8'h11; seq6[1] = 8'h22; seq6[2] = 8'h33;
        seq6[3] = 8'h44; seq6[4] = 8'h55; seq6[5] = 8'h66;

        repeat (3) @(negedge clock);
        reset = 1'b0;
        idle(5);

        // single byte
        cyc(1'b1, 8'h90, 1'b0);
        idle(340);

        // three back-to-back bytes
        for (int i = 0; i < 3; i++) cyc(1'b1, seq3[i], 1'b0);
        idle(1000);

        // five bytes fit (first pops while the rest are written)
        for (int i = 0; i < 5; i++) cyc(1'b1, seq6[i], 1'b0);
        idle(1700);

        // six bytes: last dropped, then clear-vs-set and clear alone
        for (int i = 0; i < 6; i++) cyc(1'b1, seq6[i], 1'b0);
        check("ovf_after_6th", 32'(ovf_a), 32'd1);
        cyc(1'b1, 8'hEE, 1'b1);
        check("ovf_set_wins", 32'(ovf_a), 32'd1);
        cyc(1'b0, 8'h00, 1'b1);
        check("ovf_cleared", 32'(ovf_a), 32'd0);
        idle(2000);

        // all-zero and all-one data bytes
        cyc(1'b1, 8'h00, 1'b0);
        cyc(1'b1, 8'hFF, 1'b0);
        idle(700);

        // reset in the middle of data bit 3 of 0xAA
        cyc(1'b1, 8'hAA, 1'b0);
        idle(145);
        check("busy_before_rst", 32'(busy_a), 32'd1);
        #2 reset = 1'b1;
        #1;
        check("rst_txd", 32'(txd_a), 32'd1);
        check("rst_level", 32'(level_a), 32'd0);
        check("rst_busy", 32'(busy_a), 32'd0);
        check("rst_empty", 32'(empty_a), 32'd1);
        repeat (3) @(negedge clock);
        reset = 1'b0;
        idle(400);

        // random traffic including drops and clears, then drain
        for (int i = 0; i < 400; i++)
            cyc(($urandom_range(0, 5) == 0), 8'($urandom), ($urandom_range(0, 40) == 0));
        idle(3000);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
